// File: rtl/board_pkg.sv
// Shared constants, state encoding and cell-index helpers for the 8x8 match-3 board sequencer.
package board_pkg;

    localparam int ROWS     = 8;
    localparam int COLS     = 8;
    localparam int CELLS    = ROWS * COLS;
    localparam int CELL_W   = 3;
    localparam int BOARD_W  = CELLS * CELL_W;
    localparam int NCOLOURS = 6;
    localparam int SCORE_W  = 16;
    localparam int LFSR_W   = 24;

    localparam logic [CELL_W-1:0] EMPTY     = '0;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 24'hE10000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GEN_REQ,
        ST_GEN_WAIT,
        ST_SCAN,
        ST_CLEAR,
        ST_DROP,
        ST_READY,
        ST_SWAP,
        ST_SWAP_BACK
    } state_t;

    function automatic logic [2:0] cell_row(input logic [5:0] k);
        return k[5:3];
    endfunction

    function automatic logic [2:0] cell_col(input logic [5:0] k);
        return k[2:0];
    endfunction

    // Widened to 4 bits so row/col 7 never wraps onto 0.
    function automatic logic cells_adjacent(input logic [5:0] a, input logic [5:0] b);
        logic [3:0] ra, rb, ca, cb;
        logic       row_step, col_step;
        ra = {1'b0, cell_row(a)};
        rb = {1'b0, cell_row(b)};
        ca = {1'b0, cell_col(a)};
        cb = {1'b0, cell_col(b)};
        row_step = (ra == rb + 4'd1) || (rb == ra + 4'd1);
        col_step = (ca == cb + 4'd1) || (cb == ca + 4'd1);
        return (row_step && (ca == cb)) || (col_step && (ra == rb));
    endfunction

    function automatic logic [CELL_W-1:0] refill_colour(input logic [CELL_W-1:0] v);
        logic [CELL_W-1:0] m;
        m = (v >= CELL_W'(NCOLOURS)) ? v - CELL_W'(NCOLOURS) : v;
        return m + CELL_W'(1);
    endfunction

endpackage

// File: rtl/match_finder.sv
// Combinational match detector: marks every nonzero cell that sits in a horizontal
// or vertical run of three or more equal colours.
module match_finder
    import board_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    output logic [CELLS-1:0]   mask
);

    logic [CELLS-1:0]        h_start;
    logic [CELLS-1:0]        v_start;
    logic [CELLS+1:0]        h_pad;
    logic [CELLS+2*COLS-1:0] v_pad;

    // h_start/v_start flag the first cell of each triple.
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_start
        localparam int C = gi % COLS;
        localparam int R = gi / COLS;
        logic [CELL_W-1:0] here;

        assign here = board[gi*CELL_W +: CELL_W];

        if (C <= COLS - 3) begin : g_h
            assign h_start[gi] = (here != EMPTY)
                && (here == board[(gi+1)*CELL_W +: CELL_W])
                && (here == board[(gi+2)*CELL_W +: CELL_W]);
        end else begin : g_h_edge
            assign h_start[gi] = 1'b0;
        end

        if (R <= ROWS - 3) begin : g_v
            assign v_start[gi] = (here != EMPTY)
                && (here == board[(gi+COLS)*CELL_W +: CELL_W])
                && (here == board[(gi+2*COLS)*CELL_W +: CELL_W]);
        end else begin : g_v_edge
            assign v_start[gi] = 1'b0;
        end
    end

    // Padding keeps indices non-negative; triples never start in the last two
    // columns, so looking back across a row boundary always reads zero.
    assign h_pad = {h_start, 2'b00};
    assign v_pad = {v_start, {(2*COLS){1'b0}}};

    for (genvar gi = 0; gi < CELLS; gi++) begin : g_mask
        assign mask[gi] = h_pad[gi+2] | h_pad[gi+1] | h_pad[gi]
                        | v_pad[gi+2*COLS] | v_pad[gi+COLS] | v_pad[gi];
    end

endmodule

// File: rtl/board_sequencer.sv
// Game-flow controller: owns the live board, loads generator boards, handles swaps,
// and resolves clear/gravity/refill cascades until the board is stable.
module board_sequencer
    import board_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 24'h5EED01
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               gen_fresh,
    input  logic [BOARD_W-1:0] gen_board,
    input  logic               gen_done,
    input  logic               swap_valid,
    output logic               swap_ready,
    input  logic [5:0]         swap_a,
    input  logic [5:0]         swap_b,
    output logic               swap_reject,
    output logic [BOARD_W-1:0] board,
    output logic [SCORE_W-1:0] score,
    output logic               busy
);

    state_t               state_q, state_d;
    logic [BOARD_W-1:0]   board_q, board_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 flag_q, flag_d;
    logic [5:0]           swap_a_q, swap_a_d;
    logic [5:0]           swap_b_q, swap_b_d;
    logic                 reject_q, reject_d;
    logic                 gen_fresh_q;
    logic [LFSR_W-1:0]    lfsr_q;

    logic [CELLS-1:0]     mask;
    logic [6:0]           mask_cnt;
    logic [SCORE_W:0]     score_sum;
    logic [BOARD_W-1:0]   clear_board;
    logic [BOARD_W-1:0]   drop_board;
    logic [CELLS-1:0]     drop_empty;
    logic [BOARD_W-1:0]   swap_board;

    match_finder u_match (
        .board (board_q),
        .mask  (mask)
    );

    assign mask_cnt  = 7'($countones(mask));
    assign score_sum = {1'b0, score_q} + (SCORE_W+1)'(mask_cnt);

    for (genvar gi = 0; gi < CELLS; gi++) begin : g_clear
        assign clear_board[gi*CELL_W +: CELL_W] =
            mask[gi] ? EMPTY : board_q[gi*CELL_W +: CELL_W];
    end

    // One gravity step per column: every row at or above the lowest hole moves
    // down by one and the top row takes the column's refill colour.
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        logic [ROWS-1:0]   is_zero;
        logic [CELL_W-1:0] refill;

        assign refill = refill_colour(lfsr_q[gi*CELL_W +: CELL_W]);

        for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
            localparam int K = gr * COLS + gi;
            logic shift;

            assign is_zero[gr] = (board_q[K*CELL_W +: CELL_W] == EMPTY);
            assign shift       = |is_zero[ROWS-1:gr];

            if (gr == 0) begin : g_top
                assign drop_board[K*CELL_W +: CELL_W] =
                    shift ? refill : board_q[K*CELL_W +: CELL_W];
            end else begin : g_body
                assign drop_board[K*CELL_W +: CELL_W] =
                    shift ? board_q[(K-COLS)*CELL_W +: CELL_W] : board_q[K*CELL_W +: CELL_W];
            end

            assign drop_empty[K] = (drop_board[K*CELL_W +: CELL_W] == EMPTY);
        end
    end

    always_comb begin
        swap_board = board_q;
        swap_board[swap_a_q*CELL_W +: CELL_W] = board_q[swap_b_q*CELL_W +: CELL_W];
        swap_board[swap_b_q*CELL_W +: CELL_W] = board_q[swap_a_q*CELL_W +: CELL_W];
    end

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        score_d  = score_q;
        flag_d   = flag_q;
        swap_a_d = swap_a_q;
        swap_b_d = swap_b_q;
        reject_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_GEN_REQ: begin
                state_d = ST_GEN_WAIT;
            end
            ST_GEN_WAIT: begin
                if (gen_done) begin
                    board_d = gen_board;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (mask != '0) begin
                    state_d = ST_CLEAR;
                end else if (flag_q) begin
                    state_d = ST_SWAP_BACK;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_CLEAR: begin
                board_d = clear_board;
                score_d = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
                flag_d  = 1'b0;
                state_d = ST_DROP;
            end
            ST_DROP: begin
                board_d = drop_board;
                state_d = (drop_empty != '0) ? ST_DROP : ST_SCAN;
            end
            ST_READY: begin
                if (swap_valid) begin
                    if (cells_adjacent(swap_a, swap_b)) begin
                        swap_a_d = swap_a;
                        swap_b_d = swap_b;
                        state_d  = ST_SWAP;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ST_SWAP: begin
                board_d = swap_board;
                flag_d  = 1'b1;
                state_d = ST_SCAN;
            end
            ST_SWAP_BACK: begin
                board_d  = swap_board;
                flag_d   = 1'b0;
                reject_d = 1'b1;
                state_d  = ST_READY;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new game overrides whatever is in flight; the board survives until the load.
        if (start) begin
            state_d  = ST_GEN_REQ;
            board_d  = board_q;
            score_d  = '0;
            flag_d   = 1'b0;
            reject_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            board_q     <= '0;
            score_q     <= '0;
            flag_q      <= 1'b0;
            swap_a_q    <= '0;
            swap_b_q    <= '0;
            reject_q    <= 1'b0;
            gen_fresh_q <= 1'b0;
            lfsr_q      <= SEED;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            score_q     <= score_d;
            flag_q      <= flag_d;
            swap_a_q    <= swap_a_d;
            swap_b_q    <= swap_b_d;
            reject_q    <= reject_d;
            gen_fresh_q <= (state_d == ST_GEN_REQ);
            lfsr_q      <= (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        end
    end

    assign gen_fresh   = gen_fresh_q;
    assign swap_reject = reject_q;
    assign board       = board_q;
    assign score       = score_q;
    assign swap_ready  = (state_q == ST_READY);
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_READY);

endmodule

// File: tb/tb_board_sequencer.sv
// Randomized self-checking bench for board_sequencer against a cell-array game model.
module tb_board_sequencer;

    localparam logic [23:0] SEED = 24'h5EED01;
    localparam int          HIST = 16384;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         gen_fresh;
    logic [191:0] gen_board = '0;
    logic         gen_done = 1'b0;
    logic         swap_valid = 1'b0;
    logic         swap_ready;
    logic [5:0]   swap_a = '0;
    logic [5:0]   swap_b = '0;
    logic         swap_reject;
    logic [191:0] board;
    logic [15:0]  score;
    logic         busy;

    board_sequencer #(.SEED(SEED)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .gen_fresh   (gen_fresh),
        .gen_board   (gen_board),
        .gen_done    (gen_done),
        .swap_valid  (swap_valid),
        .swap_ready  (swap_ready),
        .swap_a      (swap_a),
        .swap_b      (swap_b),
        .swap_reject (swap_reject),
        .board       (board),
        .score       (score),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    logic [23:0]  lfsr_m = SEED;
    logic [23:0]  hist [HIST];
    logic [191:0] pending = '0;
    int           m_board [64];
    bit           m_mask [64];
    int           m_score = 0;
    int           m_sa = 0;
    int           m_sb = 0;

    task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] lfsr_step(input logic [23:0] s);
        return s[0] ? ((s >> 1) ^ 24'hE10000) : (s >> 1);
    endfunction

    // Cycle counter and LFSR value held during each cycle.
    initial forever begin
        @(posedge clk);
        cyc++;
        lfsr_m = rst ? SEED : lfsr_step(lfsr_m);
        hist[cyc % HIST] = lfsr_m;
    end

    // Single-cycle stub generator with a sticky done flag.
    initial forever begin
        @(negedge clk);
        if (gen_fresh === 1'b1) begin
            gen_board = pending;
            gen_done  = 1'b1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [191:0] pack_model();
        logic [191:0] v;
        v = '0;
        for (int k = 0; k < 64; k++) v[k*3 +: 3] = 3'(m_board[k]);
        return v;
    endfunction

    function automatic void load_model(input logic [191:0] v);
        for (int k = 0; k < 64; k++) m_board[k] = int'(v[k*3 +: 3]);
    endfunction

    function automatic logic [191:0] checker_board();
        logic [191:0] v;
        v = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) v[(r*8+c)*3 +: 3] = 3'((r + c) % 2 + 1);
        return v;
    endfunction

    function automatic logic [191:0] row7_board();
        logic [191:0] v;
        int           row7 [8];
        row7 = '{3, 3, 3, 1, 2, 1, 2, 1};
        v = checker_board();
        for (int c = 0; c < 8; c++) v[(56+c)*3 +: 3] = 3'(row7[c]);
        return v;
    endfunction

    function automatic logic [191:0] random_board(input int max_colour);
        logic [191:0] v;
        for (int k = 0; k < 64; k++) v[k*3 +: 3] = 3'($urandom_range(1, max_colour));
        return v;
    endfunction

    function automatic int refill_of(input logic [23:0] lf, input int j);
        return int'((lf >> (3*j)) & 24'h7) % 6 + 1;
    endfunction

    function automatic logic [23:0] column_of(input logic [191:0] b, input int j);
        logic [23:0] col;
        for (int r = 0; r < 8; r++) col[r*3 +: 3] = b[(r*8+j)*3 +: 3];
        return col;
    endfunction

    // Marks each nonzero cell whose horizontal or vertical equal-colour run is >= 3.
    function automatic int find_matches();
        int n;
        n = 0;
        for (int k = 0; k < 64; k++) begin
            int r, c, v, h, vv;
            r = k / 8;
            c = k % 8;
            v = m_board[k];
            h = 1;
            vv = 1;
            m_mask[k] = 1'b0;
            if (v != 0) begin
                for (int x = c - 1; x >= 0 && m_board[r*8+x] == v; x--) h++;
                for (int x = c + 1; x < 8 && m_board[r*8+x] == v; x++) h++;
                for (int y = r - 1; y >= 0 && m_board[y*8+c] == v; y--) vv++;
                for (int y = r + 1; y < 8 && m_board[y*8+c] == v; y++) vv++;
                if (h >= 3 || vv >= 3) begin
                    m_mask[k] = 1'b1;
                    n++;
                end
            end
        end
        return n;
    endfunction

    function automatic void model_drop(input logic [23:0] lf);
        for (int j = 0; j < 8; j++) begin
            int low;
            low = -1;
            for (int i = 0; i < 8; i++) if (m_board[i*8+j] == 0) low = i;
            if (low >= 0) begin
                for (int i = low; i >= 1; i--) m_board[i*8+j] = m_board[(i-1)*8+j];
                m_board[j] = refill_of(lf, j);
            end
        end
    endfunction

    function automatic bit has_empty();
        for (int k = 0; k < 64; k++) if (m_board[k] == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_exchange(input int a, input int b);
        int tmp;
        tmp = m_board[a];
        m_board[a] = m_board[b];
        m_board[b] = tmp;
    endfunction

    // Walks the model from a SCAN cycle to the cycle it should next be READY.
    task automatic model_resolve(input int scan_cyc, input bit swapped,
                                 output int ready_cyc, output bit rej);
        int c, n;
        bit flag, done;
        c = scan_cyc;
        flag = swapped;
        rej = 1'b0;
        ready_cyc = -1;
        done = 1'b0;
        for (int pass = 0; pass < 64 && !done; pass++) begin
            n = find_matches();
            if (n == 0) begin
                if (flag) begin
                    model_exchange(m_sa, m_sb);
                    rej = 1'b1;
                    ready_cyc = c + 2;
                end else begin
                    ready_cyc = c + 1;
                end
                done = 1'b1;
            end else begin
                m_score = (m_score + n > 65535) ? 65535 : m_score + n;
                for (int k = 0; k < 64; k++) if (m_mask[k]) m_board[k] = 0;
                flag = 1'b0;
                c = c + 2;
                model_drop(hist[c % HIST]);
                for (int k = 0; k < 8 && has_empty(); k++) begin
                    c++;
                    model_drop(hist[c % HIST]);
                end
                c = c + 1;
            end
        end
    endtask

    task automatic settle(input int scan_cyc, input bit swapped, input string tag);
        int n, exp_ready;
        bit exp_rej;
        n = 0;
        while (swap_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, " ready"}, 192'(swap_ready), 192'(1));
        model_resolve(scan_cyc, swapped, exp_ready, exp_rej);
        check_eq({tag, " ready_cycle"}, 192'(cyc), 192'(exp_ready));
        check_eq({tag, " board"}, board, pack_model());
        check_eq({tag, " score"}, 192'(score), 192'(m_score));
        check_eq({tag, " reject"}, 192'(swap_reject), 192'(exp_rej));
        check_eq({tag, " busy"}, 192'(busy), 192'(0));
        $display("%s: ready at cycle %0d score %0d reject %0b", tag, cyc, score, swap_reject);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " board"}, board, 192'(0));
        check_eq({tag, " score"}, 192'(score), 192'(0));
        check_eq({tag, " busy"}, 192'(busy), 192'(0));
        check_eq({tag, " swap_ready"}, 192'(swap_ready), 192'(0));
        check_eq({tag, " gen_fresh"}, 192'(gen_fresh), 192'(0));
        check_eq({tag, " swap_reject"}, 192'(swap_reject), 192'(0));
        $display("%s: reset outputs sampled at cycle %0d", tag, cyc);
    endtask

    task automatic start_game(input logic [191:0] gb, input bit detail, input string tag);
        int t;
        pending = gb;
        t = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (detail) begin
            check_eq({tag, " gen_fresh_t1"}, 192'(gen_fresh), 192'(1));
            check_eq({tag, " score_t1"}, 192'(score), 192'(0));
            @(negedge clk);
            check_eq({tag, " gen_fresh_t2"}, 192'(gen_fresh), 192'(0));
            @(negedge clk);
            check_eq({tag, " board_t3"}, board, gb);
        end
        load_model(gb);
        m_score = 0;
        settle(t + 3, 1'b0, tag);
    endtask

    task automatic do_swap(input int a, input int b, input string tag);
        int t, dr, dc;
        bit adj;
        t = cyc;
        swap_a = 6'(a);
        swap_b = 6'(b);
        swap_valid = 1'b1;
        @(negedge clk);
        swap_valid = 1'b0;
        dr = (a / 8) - (b / 8);
        dc = (a % 8) - (b % 8);
        adj = ((dr < 0 ? -dr : dr) + (dc < 0 ? -dc : dc)) == 1;
        if (!adj) begin
            check_eq({tag, " nonadj_reject"}, 192'(swap_reject), 192'(1));
            check_eq({tag, " nonadj_board"}, board, pack_model());
            check_eq({tag, " nonadj_ready"}, 192'(swap_ready), 192'(1));
            @(negedge clk);
            check_eq({tag, " nonadj_pulse_end"}, 192'(swap_reject), 192'(0));
            $display("%s: swap %0d<->%0d refused as non-adjacent", tag, a, b);
        end else begin
            m_sa = a;
            m_sb = b;
            model_exchange(a, b);
            settle(t + 2, 1'b1, tag);
        end
    endtask

    initial begin
        logic [191:0] rb, nb, exp_b;
        logic [23:0]  exp_col;
        int           t, a, b, dir;

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        start_game(checker_board(), 1'b1, "checker");
        do_swap(0, 2, "swap_0_2");
        do_swap(0, 1, "swap_0_1");

        // Single three-cell clear in row 7 followed by one gravity step.
        rb = row7_board();
        pending = rb;
        t = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("row7 score_after_clear", 192'(score), 192'(3));
        check_eq("row7 busy_in_drop", 192'(busy), 192'(1));
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            for (int r = 1; r < 8; r++) exp_col[r*3 +: 3] = rb[((r-1)*8+j)*3 +: 3];
            exp_col[2:0] = 3'(refill_of(hist[(t + 5) % HIST], j));
            check_eq($sformatf("row7 col%0d_after_drop", j), 192'(column_of(board, j)), 192'(exp_col));
        end
        load_model(rb);
        m_score = 0;
        settle(t + 3, 1'b0, "row7");

        // New game requested while the previous one is mid-DROP.
        pending = rb;
        t = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        nb = random_board(6);
        pending = nb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_b = rb;
        for (int c = 0; c < 3; c++) exp_b[(56+c)*3 +: 3] = 3'd0;
        check_eq("restart gen_fresh", 192'(gen_fresh), 192'(1));
        check_eq("restart score", 192'(score), 192'(0));
        check_eq("restart busy", 192'(busy), 192'(1));
        check_eq("restart board_kept", board, exp_b);
        repeat (2) @(negedge clk);
        check_eq("restart board_loaded", board, nb);
        load_model(nb);
        m_score = 0;
        settle(t + 8, 1'b0, "restart");

        // Reset held for two cycles in the middle of a DROP.
        pending = rb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid_drop1");
        @(negedge clk);
        check_reset_outputs("rst_mid_drop2");
        rst = 1'b0;
        @(negedge clk);

        for (int g = 0; g < 8; g++) begin
            start_game(random_board((g % 2 == 0) ? 7 : 4), g == 0, $sformatf("game%0d", g));
            for (int s = 0; s < 8; s++) begin
                a = $urandom_range(0, 63);
                dir = $urandom_range(0, 4);
                b = a;
                case (dir)
                    0: if (a >= 8) b = a - 8;
                    1: if (a < 56) b = a + 8;
                    2: if (a % 8 != 0) b = a - 1;
                    3: if (a % 8 != 7) b = a + 1;
                    default: b = $urandom_range(0, 63);
                endcase
                do_swap(a, b, $sformatf("game%0d_swap%0d", g, s));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/board_sequencer.md
# board_sequencer

Game-flow controller for the 8×8 match-3 board. Owns the live board register and sequences the board generator, swap requests, match clearing, gravity drop and refill. Resolves cascades until the board is stable. Sits between the input/UI logic, which issues swaps, and the board generator; it drives the board to the display path.

## Interface
- `SEED`, default 24'h5EED01: LFSR reset value for refill colours (must be nonzero).
- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a new game; level sampled each cycle.
- `gen_fresh`  out  1  one-cycle request to board generator.
- `gen_board`  in  192  generator board, cell k at bits [3k+:3].
- `gen_done`  in  1  generator has produced a board (may be sticky).
- `swap_valid`  in  1  swap request.
- `swap_ready`  out  1  high only in READY.
- `swap_a`, `swap_b`  in  6 each  cell indices, k = row*8+col; row 0 is the top.
- `swap_reject`  out  1  one-cycle pulse: swap refused or undone.
- `board`  out  192  live board; 0 = empty, 1..6 = colours.
- `score`  out  16  cells cleared since `start`, saturating at 16'hFFFF.
- `busy`  out  1  state ∉ {IDLE, READY}.

## Operation
- States:
  - IDLE: reset state.
  - GEN_REQ: `gen_fresh`=1, then go to GEN_WAIT.
  - GEN_WAIT: when `gen_done`, load `board`←`gen_board` and go to SCAN.
  - SCAN: evaluate match mask. If nonzero, go to CLEAR. If zero and the swap flag is set, go to SWAP_BACK. Otherwise go to READY.
  - CLEAR: zero the masked cells, `score` += popcount(mask) (saturating), clear the swap flag, go to DROP.
  - DROP: repeats until no cell is 0, then goes to SCAN.
  - READY: accepts swaps.
  - SWAP: exchange cells a/b, set the swap flag, go to SCAN.
  - SWAP_BACK: exchange a/b again, pulse `swap_reject`, go to READY.
- Match mask:
  - A cell is marked if it is nonzero and belongs to a horizontal or vertical run of ≥3 equal colours.
  - Overlapping runs are counted once per cell.
- DROP step, per column, all columns in parallel in one cycle:
  - Let r be the lowest row holding 0. Rows 1..r take the value from the row above; row 0 takes the refill colour.
  - Columns with no 0 are unchanged.
- Refill colour for column j: (lfsr[3j+:3] % 6) + 1.
- LFSR:
  - 24-bit Galois, taps 24'hE10000, reset to `SEED`.
  - Advances every cycle when not in reset.
- Swap handshake:
  - Accepted on `swap_valid && swap_ready`.
  - Adjacent means |Δrow|+|Δcol| = 1. Adjacent requests go to SWAP.
  - A non-adjacent request (including a == b) stays in READY and pulses `swap_reject` the next cycle.
- `start` has priority in every state, including mid-DROP, SWAP and GEN_WAIT:
  - Next state is GEN_REQ, `score`←0, swap flag cleared.
  - The board is kept until the generator load.
- Reset: state IDLE, `board`=0, `score`=0, all strobes 0, LFSR=`SEED`.
- Cell value 7 from the generator is treated as a colour. It is not matched specially.

## Timing
- `start` at cycle t:
  - `gen_fresh` is high in t+1 only.
  - GEN_WAIT runs from t+2. With a single-cycle generator, `board` is valid at t+3.
  - SCAN at t+3; READY at t+4 if there is no match.
- Rejected (no-match) swap accepted at t:
  - SWAP at t+1, SCAN at t+2, SWAP_BACK at t+3.
  - `swap_reject` is high at t+4 in READY.
  - `board` is identical to pre-swap at t+4.
- Non-adjacent swap at t: `swap_reject` is high at t+1; `board` is unchanged.
- Per cascade: 1 SCAN + 1 CLEAR + N DROP cycles, where N = max empties in any column (1..8).
- `gen_done` held high from a previous game is accepted on the first GEN_WAIT cycle. This is valid because the generator updates on the `gen_fresh` edge.
- All outputs are registered; `swap_ready` and `busy` are decoded from the state register.

## Structure
- `board_pkg`:
  - Constants: ROWS=8, COLS=8, CELL_W=3, BOARD_W=192, EMPTY=0, NCOLOURS=6, LFSR_TAPS.
  - State enum.
  - Cell-index helper functions for row/col.
- Sub-module `match_finder`: purely combinational, `board`[191:0] → `mask`[63:0]. It is instantiated once and reused by SCAN and CLEAR.
- Gravity/refill and the LFSR stay inside `board_sequencer`.

## Test plan
- Reset is asserted for 2 cycles mid-DROP.
  - Required: `board`=0, `score`=0, `busy`=0, `swap_ready`=0, `gen_fresh`=0 and `swap_reject`=0 next cycle.
- `start` with a stub generator returning checkerboard colour (row+col)%2+1.
  - Required: `gen_fresh` pulse at t+1, `board`=stub at t+3, READY at t+4, `score`=0.
- On the checkerboard, swap a=0, b=2.
  - Required: `swap_reject` at t+1, board unchanged.
- On the checkerboard, swap a=0, b=1 (no match).
  - Required: `swap_reject` at t+4, board equals original, `score`=0.
- Stub = checkerboard with row 7 = 3,3,3,1,2,1,2,1.
  - First pass: SCAN marks 3 cells, `score`=3, then one DROP cycle.
  - Check: columns 0–2 rows 1..7 equal old rows 0..6; row 0 cells equal the LFSR refill.
  - Further cascades are checked against a reference model seeded with `SEED`.
- `start` asserted during DROP.
  - Required: next cycle GEN_REQ, `score`=0, `gen_fresh` pulse, new board loaded.
